dispatch_scheduler: RTL and testbench

//  In-order dispatch controller between the 4-wide instruction buffer and the reservation stations
//  (fxu_0, fxu_1, lsu, branch). It holds one decoded issue group and sends up to 4 slots per cycle
//  to free units, allocating ROB tags. Blocked slots stay held, and the next group is accepted only

---
 rtl/dispatch_pkg.sv | 32 +++
 rtl/dispatch_scheduler_if.sv | 24 ++
 rtl/dispatch_slot_pick.sv | 86 ++++++++
 rtl/dispatch_scheduler.sv | 132 +++++++++++++
 tb/tb_dispatch_scheduler.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dispatch_pkg.sv
// Shared types, constants and the opcode classifier for the dispatch scheduler.
package dispatch_pkg;

    localparam int unsigned GROUP_W   = 4;
    localparam int unsigned TAG_W     = 4;
    localparam int unsigned ROB_DEPTH = 16;

    // Unit indices used for per-unit issue vectors.
    localparam logic [1:0] UNIT_FXU0 = 2'd0;
    localparam logic [1:0] UNIT_FXU1 = 2'd1;
    localparam logic [1:0] UNIT_LSU  = 2'd2;
    localparam logic [1:0] UNIT_BR   = 2'd3;

    typedef enum logic [1:0] {
        CLS_FXU,
        CLS_LSU,
        CLS_BR,
        CLS_NOP
    } op_class_e;

    function automatic op_class_e op_class(input logic [3:0] opcode);
        if (opcode < 4'd8) begin
            return CLS_FXU;
        end else if (opcode < 4'd12) begin
            return CLS_LSU;
        end else if (opcode < 4'd15) begin
            return CLS_BR;
        end
        return CLS_NOP;
    endfunction

endpackage

// File: rtl/dispatch_scheduler_if.sv
// Issue-group handshake between the instruction buffer (master) and the scheduler (slave).
interface dispatch_scheduler_if;
    import dispatch_pkg::*;

    logic                   grp_valid;
    logic                   grp_ready;
    logic [GROUP_W-1:0]     grp_slot_valid;
    logic [4*GROUP_W-1:0]   grp_opcode;

    modport master (
        output grp_valid,
        output grp_slot_valid,
        output grp_opcode,
        input  grp_ready
    );

    modport slave (
        input  grp_valid,
        input  grp_slot_valid,
        input  grp_opcode,
        output grp_ready
    );

endinterface

// File: rtl/dispatch_slot_pick.sv
// In-order slot scan: decides which held slots dispatch this cycle, to which unit,
// and at which offset from the ROB tail.
module dispatch_slot_pick
    import dispatch_pkg::*;
(
    input  logic [GROUP_W-1:0]   held_i,
    input  logic [4*GROUP_W-1:0] op_i,
    input  logic                 rr_i,
    input  logic [3:0]           full_i,      // {br, lsu, fxu1, fxu0}
    input  logic [4:0]           rob_free_i,
    output logic [GROUP_W-1:0]   go_o,
    output logic [GROUP_W-1:0]   uses_rob_o,
    output logic [1:0]           unit_o [GROUP_W],
    output logic [1:0]           off_o  [GROUP_W],
    output logic [2:0]           alloc_o
);

    logic      blocked;
    logic      can;
    logic [3:0] used;
    logic [2:0] cnt;
    logic [1:0] pref;
    logic [1:0] alt;
    op_class_e cls;

    // Walk slots low to high; the first held slot that cannot go blocks all later ones.
    always_comb begin
        go_o       = '0;
        uses_rob_o = '0;
        blocked    = 1'b0;
        can        = 1'b0;
        used       = '0;
        cnt        = '0;
        pref       = {1'b0, rr_i};
        alt        = {1'b0, ~rr_i};
        cls        = CLS_NOP;
        for (int i = 0; i < GROUP_W; i++) begin
            unit_o[i] = UNIT_FXU0;
            off_o[i]  = cnt[1:0];
            can       = 1'b0;
            cls       = op_class(op_i[4*i +: 4]);
            if (held_i[i] && !blocked) begin
                if (cls == CLS_NOP) begin
                    can = 1'b1;
                end else if ({2'b00, cnt} < rob_free_i) begin
                    case (cls)
                        CLS_FXU: begin
                            if (!full_i[pref] && !used[pref]) begin
                                unit_o[i] = pref;
                                can       = 1'b1;
                            end else if (!full_i[alt] && !used[alt]) begin
                                unit_o[i] = alt;
                                can       = 1'b1;
                            end
                        end
                        CLS_LSU: begin
                            if (!full_i[UNIT_LSU] && !used[UNIT_LSU]) begin
                                unit_o[i] = UNIT_LSU;
                                can       = 1'b1;
                            end
                        end
                        CLS_BR: begin
                            if (!full_i[UNIT_BR] && !used[UNIT_BR]) begin
                                unit_o[i] = UNIT_BR;
                                can       = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                if (can) begin
                    go_o[i] = 1'b1;
                    if (cls != CLS_NOP) begin
                        used[unit_o[i]] = 1'b1;
                        uses_rob_o[i]   = 1'b1;
                        cnt             = cnt + 3'd1;
                    end
                end else begin
                    blocked = 1'b1;
                end
            end
        end
        alloc_o = cnt;
    end

endmodule

// File: rtl/dispatch_scheduler.sv
// Holds one issue group, dispatches it in order to the reservation stations and
// allocates ROB tags; accepts the next group once the held one drains.
module dispatch_scheduler
    import dispatch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [TAG_W-1:0]     flush_tail,
    dispatch_scheduler_if.slave  grp,
    input  logic                 fxu0_full,
    input  logic                 fxu1_full,
    input  logic                 lsu_full,
    input  logic                 br_full,
    input  logic [4:0]           rob_free,
    output logic                 fxu0_issue,
    output logic                 fxu1_issue,
    output logic                 lsu_issue,
    output logic                 br_issue,
    output logic [1:0]           fxu0_slot,
    output logic [1:0]           fxu1_slot,
    output logic [1:0]           lsu_slot,
    output logic [1:0]           br_slot,
    output logic [TAG_W-1:0]     fxu0_tag,
    output logic [TAG_W-1:0]     fxu1_tag,
    output logic [TAG_W-1:0]     lsu_tag,
    output logic [TAG_W-1:0]     br_tag,
    output logic [2:0]           rob_alloc,
    output logic [TAG_W-1:0]     rob_tail
);

    logic [GROUP_W-1:0]   held_q, held_d;
    logic [4*GROUP_W-1:0] op_q, op_d;
    logic                 rr_q, rr_d;
    logic [TAG_W-1:0]     rob_tail_q, rob_tail_d;

    logic [GROUP_W-1:0]   go, uses_rob;
    logic [1:0]           unit [GROUP_W];
    logic [1:0]           off  [GROUP_W];
    logic [2:0]           alloc;

    logic [3:0]           issue_v;
    logic [1:0]           slot_v [4];
    logic [TAG_W-1:0]     tag_v  [4];
    logic                 grp_ready_c;
    logic                 accept;

    dispatch_slot_pick u_pick (
        .held_i     (held_q),
        .op_i       (op_q),
        .rr_i       (rr_q),
        .full_i     ({br_full, lsu_full, fxu1_full, fxu0_full}),
        .rob_free_i (rob_free),
        .go_o       (go),
        .uses_rob_o (uses_rob),
        .unit_o     (unit),
        .off_o      (off),
        .alloc_o    (alloc)
    );

    // Route each dispatching slot onto its unit's strobe, slot and tag; flush masks all.
    always_comb begin
        issue_v = '0;
        for (int u = 0; u < 4; u++) begin
            slot_v[u] = '0;
            tag_v[u]  = '0;
        end
        for (int i = 0; i < GROUP_W; i++) begin
            if (!flush && go[i] && uses_rob[i]) begin
                issue_v[unit[i]] = 1'b1;
                slot_v[unit[i]]  = 2'(i);
                tag_v[unit[i]]   = rob_tail_q + {2'b00, off[i]};
            end
        end
    end

    assign fxu0_issue = issue_v[UNIT_FXU0];
    assign fxu1_issue = issue_v[UNIT_FXU1];
    assign lsu_issue  = issue_v[UNIT_LSU];
    assign br_issue   = issue_v[UNIT_BR];
    assign fxu0_slot  = slot_v[UNIT_FXU0];
    assign fxu1_slot  = slot_v[UNIT_FXU1];
    assign lsu_slot   = slot_v[UNIT_LSU];
    assign br_slot    = slot_v[UNIT_BR];
    assign fxu0_tag   = tag_v[UNIT_FXU0];
    assign fxu1_tag   = tag_v[UNIT_FXU1];
    assign lsu_tag    = tag_v[UNIT_LSU];
    assign br_tag     = tag_v[UNIT_BR];

    assign rob_alloc     = flush ? 3'd0 : alloc;
    assign rob_tail      = rob_tail_q;
    // Ready when nothing would remain held after this cycle's dispatch.
    assign grp_ready_c   = ~flush & ((held_q & ~go) == '0);
    assign grp.grp_ready = grp_ready_c;
    assign accept        = grp.grp_valid & grp_ready_c;

    // Next-state: drain dispatched slots, load new group, advance tail; flush overrides.
    always_comb begin
        held_d     = held_q & ~go;
        op_d       = op_q;
        rr_d       = rr_q;
        rob_tail_d = rob_tail_q + {1'b0, rob_alloc};
        // Toggle only when the preferred FXU was the sole FXU used.
        if ((issue_v[UNIT_FXU0] ^ issue_v[UNIT_FXU1]) && issue_v[{1'b0, rr_q}]) begin
            rr_d = ~rr_q;
        end
        if (accept) begin
            held_d = grp.grp_slot_valid;
            op_d   = grp.grp_opcode;
        end
        if (flush) begin
            held_d     = '0;
            rob_tail_d = flush_tail;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            held_q     <= '0;
            op_q       <= '0;
            rr_q       <= 1'b0;
            rob_tail_q <= '0;
        end else begin
            held_q     <= held_d;
            op_q       <= op_d;
            rr_q       <= rr_d;
            rob_tail_q <= rob_tail_d;
        end
    end

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Directed bench for dispatch_scheduler with an expected-issue scoreboard.
module tb_dispatch_scheduler;
    import dispatch_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [3:0] flush_tail;
    logic       fxu0_full, fxu1_full, lsu_full, br_full;
    logic [4:0] rob_free;
    logic       fxu0_issue, fxu1_issue, lsu_issue, br_issue;
    logic [1:0] fxu0_slot, fxu1_slot, lsu_slot, br_slot;
    logic [3:0] fxu0_tag, fxu1_tag, lsu_tag, br_tag;
    logic [2:0] rob_alloc;
    logic [3:0] rob_tail;

    dispatch_scheduler_if bus ();

    dispatch_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .flush_tail (flush_tail),
        .grp        (bus),
        .fxu0_full  (fxu0_full),
        .fxu1_full  (fxu1_full),
        .lsu_full   (lsu_full),
        .br_full    (br_full),
        .rob_free   (rob_free),
        .fxu0_issue (fxu0_issue),
        .fxu1_issue (fxu1_issue),
        .lsu_issue  (lsu_issue),
        .br_issue   (br_issue),
        .fxu0_slot  (fxu0_slot),
        .fxu1_slot  (fxu1_slot),
        .lsu_slot   (lsu_slot),
        .br_slot    (br_slot),
        .fxu0_tag   (fxu0_tag),
        .fxu1_tag   (fxu1_tag),
        .lsu_tag    (lsu_tag),
        .br_tag     (br_tag),
        .rob_alloc  (rob_alloc),
        .rob_tail   (rob_tail)
    );

    always #5 clk = ~clk;

    // Unit order: 0 fxu0, 1 fxu1, 2 lsu, 3 br.
    logic [3:0] iss_v;
    logic [1:0] slot_v [4];
    logic [3:0] tag_v  [4];
    assign iss_v     = {br_issue, lsu_issue, fxu1_issue, fxu0_issue};
    assign slot_v[0] = fxu0_slot;
    assign slot_v[1] = fxu1_slot;
    assign slot_v[2] = lsu_slot;
    assign slot_v[3] = br_slot;
    assign tag_v[0]  = fxu0_tag;
    assign tag_v[1]  = fxu1_tag;
    assign tag_v[2]  = lsu_tag;
    assign tag_v[3]  = br_tag;

    typedef struct {
        int unit;
        int slot;
        int tag;
    } iss_t;

    iss_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int u, input int s, input int t);
        iss_t e;
        e.unit = u;
        e.slot = s;
        e.tag  = t;
        sbq.push_back(e);
    endtask

    // Pop every expected issue for this cycle; any unit not expected must be idle.
    task automatic check_issues(input string tag);
        logic [3:0] seen;
        iss_t       e;
        seen = '0;
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            seen[e.unit] = 1'b1;
            chk($sformatf("%s_iss_u%0d", tag, e.unit), {31'd0, iss_v[e.unit]}, 32'd1);
            chk($sformatf("%s_slot_u%0d", tag, e.unit), {30'd0, slot_v[e.unit]}, e.slot);
            chk($sformatf("%s_tag_u%0d", tag, e.unit), {28'd0, tag_v[e.unit]}, e.tag);
        end
        for (int u = 0; u < 4; u++) begin
            if (!seen[u]) chk($sformatf("%s_idle_u%0d", tag, u), {31'd0, iss_v[u]}, 32'd0);
        end
    endtask

    function automatic logic [15:0] ops(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] c, input logic [3:0] d);
        return {d, c, b, a};
    endfunction

    task automatic offer(input logic [3:0] sv, input logic [15:0] op);
        bus.grp_valid      = 1'b1;
        bus.grp_slot_valid = sv;
        bus.grp_opcode     = op;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; flush_tail = '0;
        fxu0_full = 1'b0; fxu1_full = 1'b0; lsu_full = 1'b0; br_full = 1'b0;
        rob_free = 5'd16;
        bus.grp_valid = 1'b0; bus.grp_slot_valid = '0; bus.grp_opcode = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; #2;
        chk("rst_ready", {31'd0, bus.grp_ready}, 1);
        chk("rst_alloc", {29'd0, rob_alloc}, 0);
        chk("rst_tail", {28'd0, rob_tail}, 0);
        check_issues("rst");

        // Full-width group to four distinct units.
        @(negedge clk); offer(4'hF, ops(4'd1, 4'd8, 4'd12, 4'd2)); #2;
        chk("t1_acc_ready", {31'd0, bus.grp_ready}, 1);
        check_issues("t1_acc");
        @(negedge clk); bus.grp_valid = 1'b0;
        push(0, 0, 0); push(2, 1, 1); push(3, 2, 2); push(1, 3, 3); #2;
        check_issues("t1");
        chk("t1_alloc", {29'd0, rob_alloc}, 4);
        chk("t1_ready", {31'd0, bus.grp_ready}, 1);

        // Second LD blocks behind the first.
        @(negedge clk); offer(4'hF, ops(4'd8, 4'd9, 4'd1, 4'd2)); #2;
        chk("t2_tail", {28'd0, rob_tail}, 4);
        @(negedge clk); bus.grp_valid = 1'b0; push(2, 0, 4); #2;
        check_issues("t2a");
        chk("t2a_alloc", {29'd0, rob_alloc}, 1);
        chk("t2a_ready", {31'd0, bus.grp_ready}, 0);
        @(negedge clk); push(2, 1, 5); push(0, 2, 6); push(1, 3, 7); #2;
        check_issues("t2b");
        chk("t2b_alloc", {29'd0, rob_alloc}, 3);
        chk("t2b_ready", {31'd0, bus.grp_ready}, 1);

        // Flush loads tail 14, then tags wrap.
        @(negedge clk); flush = 1'b1; flush_tail = 4'd14; #2;
        chk("t3_flush_ready", {31'd0, bus.grp_ready}, 0);
        chk("t3_pre_tail", {28'd0, rob_tail}, 8);
        @(negedge clk); flush = 1'b0; offer(4'hF, ops(4'd3, 4'd9, 4'd13, 4'd4)); #2;
        chk("t3_tail14", {28'd0, rob_tail}, 14);
        @(negedge clk); bus.grp_valid = 1'b0;
        push(0, 0, 14); push(2, 1, 15); push(3, 2, 0); push(1, 3, 1); #2;
        check_issues("t3");
        chk("t3_alloc", {29'd0, rob_alloc}, 4);

        // rob_free=1 limits to one ROB entry; NOPs ride along.
        @(negedge clk); rob_free = 5'd1; offer(4'hF, ops(4'd1, 4'd15, 4'd2, 4'd15)); #2;
        chk("t4_tail", {28'd0, rob_tail}, 2);
        @(negedge clk); bus.grp_valid = 1'b0; push(0, 0, 2); #2;
        check_issues("t4a");
        chk("t4a_alloc", {29'd0, rob_alloc}, 1);
        chk("t4a_ready", {31'd0, bus.grp_ready}, 0);
        @(negedge clk); push(1, 2, 3); #2;
        check_issues("t4b");
        chk("t4b_alloc", {29'd0, rob_alloc}, 1);
        chk("t4b_ready", {31'd0, bus.grp_ready}, 1);
        @(negedge clk); rob_free = 5'd16; #2;
        chk("t4_tail_end", {28'd0, rob_tail}, 4);

        // fxu0 full: back-to-back singles all on fxu1, then rr alternation.
        @(negedge clk); fxu0_full = 1'b1; offer(4'h1, ops(4'd1, 4'd15, 4'd15, 4'd15)); #2;
        chk("t5_acc_ready", {31'd0, bus.grp_ready}, 1);
        @(negedge clk); push(1, 0, 4); #2;
        check_issues("t5a");
        chk("t5a_ready", {31'd0, bus.grp_ready}, 1);
        @(negedge clk); push(1, 0, 5); #2;
        check_issues("t5b");
        chk("t5b_ready", {31'd0, bus.grp_ready}, 1);
        @(negedge clk); bus.grp_valid = 1'b0; push(1, 0, 6); #2;
        check_issues("t5c");
        @(negedge clk); fxu0_full = 1'b0; offer(4'h1, ops(4'd1, 4'd15, 4'd15, 4'd15)); #2;
        check_issues("t5_gap");
        @(negedge clk); push(0, 0, 7); #2;
        check_issues("t5d");
        @(negedge clk); bus.grp_valid = 1'b0; push(1, 0, 8); #2;
        check_issues("t5e");

        // Empty group is accepted and dropped.
        @(negedge clk); offer(4'h0, ops(4'd1, 4'd1, 4'd1, 4'd1)); #2;
        chk("t7_ready", {31'd0, bus.grp_ready}, 1);
        chk("t7_tail", {28'd0, rob_tail}, 9);
        @(negedge clk); bus.grp_valid = 1'b0; #2;
        check_issues("t7");
        chk("t7_after_ready", {31'd0, bus.grp_ready}, 1);
        chk("t7_alloc", {29'd0, rob_alloc}, 0);

        // Both FXUs full, then rob_free=0: held group stalls completely.
        @(negedge clk); fxu0_full = 1'b1; fxu1_full = 1'b1;
        offer(4'hF, ops(4'd1, 4'd2, 4'd3, 4'd4)); #2;
        @(negedge clk); bus.grp_valid = 1'b0; #2;
        check_issues("t8_full");
        chk("t8_full_ready", {31'd0, bus.grp_ready}, 0);
        chk("t8_full_alloc", {29'd0, rob_alloc}, 0);
        @(negedge clk); fxu0_full = 1'b0; fxu1_full = 1'b0; rob_free = 5'd0; #2;
        check_issues("t8_rob0");
        chk("t8_rob0_ready", {31'd0, bus.grp_ready}, 0);
        @(negedge clk); rob_free = 5'd16; push(0, 0, 9); push(1, 1, 10); #2;
        check_issues("t8a");
        chk("t8a_alloc", {29'd0, rob_alloc}, 2);
        chk("t8a_ready", {31'd0, bus.grp_ready}, 0);
        @(negedge clk); push(0, 2, 11); push(1, 3, 12); #2;
        check_issues("t8b");
        chk("t8b_ready", {31'd0, bus.grp_ready}, 1);

        // Flush mid-group with a concurrent offer.
        @(negedge clk); offer(4'hF, ops(4'd1, 4'd8, 4'd9, 4'd2)); #2;
        chk("t6_tail", {28'd0, rob_tail}, 13);
        @(negedge clk); bus.grp_valid = 1'b0; push(0, 0, 13); push(2, 1, 14); #2;
        check_issues("t6a");
        chk("t6a_alloc", {29'd0, rob_alloc}, 2);
        @(negedge clk); flush = 1'b1; flush_tail = 4'd5;
        offer(4'hF, ops(4'd1, 4'd1, 4'd1, 4'd1)); #2;
        check_issues("t6_flush");
        chk("t6_flush_ready", {31'd0, bus.grp_ready}, 0);
        chk("t6_flush_alloc", {29'd0, rob_alloc}, 0);
        @(negedge clk); flush = 1'b0; bus.grp_valid = 1'b0; #2;
        check_issues("t6_post");
        chk("t6_post_tail", {28'd0, rob_tail}, 5);
        chk("t6_post_ready", {31'd0, bus.grp_ready}, 1);

        // Reset beats flush mid-group.
        @(negedge clk); offer(4'hF, ops(4'd8, 4'd9, 4'd8, 4'd9)); #2;
        @(negedge clk); bus.grp_valid = 1'b0; push(2, 0, 5); #2;
        check_issues("t9a");
        @(negedge clk); rst_n = 1'b0; flush = 1'b1; flush_tail = 4'd9; #2;
        check_issues("t9_rst");
        @(negedge clk); rst_n = 1'b1; flush = 1'b0; #2;
        chk("t9_tail", {28'd0, rob_tail}, 0);
        chk("t9_ready", {31'd0, bus.grp_ready}, 1);
        check_issues("t9_post");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
